// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 host transmit path.
//
// Contents:
//   BYTE_WIDTH                 width of a PS/2 command byte
//   ps2_tx_state_t             state encoding of the host transmit FSM
//   PS2_CMD_RESET              device reset command (0xFF)
//   PS2_CMD_ENABLE_REPORTING   enable data reporting command (0xF4)
//   odd_parity()               parity bit that makes the frame odd
package ps2_pkg;

    localparam int BYTE_WIDTH = 8;

    localparam logic [BYTE_WIDTH-1:0] PS2_CMD_RESET            = 8'hFF;
    localparam logic [BYTE_WIDTH-1:0] PS2_CMD_ENABLE_REPORTING = 8'hF4;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        DATA,
        PARITY,
        STOP,
        ACK
    } ps2_tx_state_t;

    // PS/2 frames carry odd parity: the parity bit is 1 when the byte
    // holds an even number of ones.
    function automatic logic odd_parity(input logic [BYTE_WIDTH-1:0] value);
        return ~^value;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync -- brings the raw PS/2 clock and data lines into the
// system clock domain and flags falling edges of the PS/2 clock.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   ps2_clk    raw PS/2 clock line level (asynchronous)
//   ps2_data   raw PS/2 data line level (asynchronous)
//   clk_fall   one-cycle pulse on a falling edge of the synchronised clock
//   data_sync  synchronised PS/2 data level
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_fall,
    output logic data_sync
);

    logic [1:0] clk_meta;
    logic [1:0] data_meta;
    logic       clk_prev;

    // Two-flop synchronisers for both lines plus one extra stage on the
    // clock for edge detection. Everything resets to the idle-high bus
    // level so that leaving reset never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta  <= 2'b11;
            data_meta <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_meta  <= {clk_meta[0], ps2_clk};
            data_meta <= {data_meta[0], ps2_data};
            clk_prev  <= clk_meta[1];
        end
    end

    // Clock and data pass through equal-length chains, so data_sync is
    // aligned with the cycle in which clk_fall fires.
    assign clk_fall  = clk_prev & ~clk_meta[1];
    assign data_sync = data_meta[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 command transmitter.
//
// Sends one byte to a PS/2 device: inhibits the bus, issues the start
// bit, shifts data LSB first on device clock falling edges, then parity,
// stop and checks the device acknowledge bit.
//
// Parameters:
//   CLK_FREQ_HZ     system clock frequency
//   INHIBIT_CYCLES  clock-low hold before the start bit (100 us)
//   TIMEOUT_CYCLES  whole-transfer watchdog limit (20 ms)
//
// Ports:
//   clk               system clock
//   rst               asynchronous active-high reset
//   i_byte            command byte to send
//   i_valid           send request, accepted only while o_ready
//   o_ready           high only while idle
//   io_clk_mouse      raw PS/2 clock line level
//   io_data_mouse     raw PS/2 data line level
//   o_clk_drive_low   open-drain pull-down enable, PS/2 clock
//   o_data_drive_low  open-drain pull-down enable, PS/2 data
//   o_done            one-cycle pulse: byte acknowledged
//   o_error           one-cycle pulse: NACK (or watchdog timeout)
//
// Build option:
//   PS2_TX_TIMEOUT_EN  compiles in the whole-transfer watchdog. Without it
//                      a silent device leaves the FSM waiting until reset.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int INHIBIT_CYCLES = CLK_FREQ_HZ / 10000,
    parameter int TIMEOUT_CYCLES = CLK_FREQ_HZ / 50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_WIDTH-1:0] i_byte,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  io_clk_mouse,
    input  logic                  io_data_mouse,
    output logic                  o_clk_drive_low,
    output logic                  o_data_drive_low,
    output logic                  o_done,
    output logic                  o_error
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INHIBIT_LAST = INH_W'(INHIBIT_CYCLES - 1);

    ps2_tx_state_t         state;
    ps2_tx_state_t         next_state;
    logic [BYTE_WIDTH-1:0] tx_byte;
    logic                  tx_parity;
    logic [3:0]            edge_cnt;
    logic [INH_W-1:0]      inhibit_cnt;
    logic                  ack_bit;
    logic [2:0]            bit_idx;
    logic                  clk_fall;
    logic                  data_sync;
    logic                  timeout;

    ps2_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (io_clk_mouse),
        .ps2_data  (io_data_mouse),
        .clk_fall  (clk_fall),
        .data_sync (data_sync)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] TIMEOUT_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    // Watchdog counts every cycle spent outside IDLE, starting at zero in
    // the first cycle after the request is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == IDLE) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Once the ACK state is reached the outcome is already decided, so
    // the watchdog no longer intervenes there.
    assign timeout = (state != IDLE) && (state != ACK) && (wd_cnt == TIMEOUT_LAST);
`else
    // The limit parameter stays in the interface so both builds share one
    // instantiation; it has no effect when the watchdog is left out.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout = 1'b0;
`endif

    // Edge count 1..8 maps to data bits 0..7.
    assign bit_idx = 3'(edge_cnt - 4'd1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath: latch the request in IDLE, time the inhibit, and count
    // device clock edges only once the host has handed the clock over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_byte     <= '0;
            tx_parity   <= 1'b0;
            edge_cnt    <= '0;
            inhibit_cnt <= '0;
            ack_bit     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        tx_byte   <= i_byte;
                        tx_parity <= odd_parity(i_byte);
                    end
                    edge_cnt    <= '0;
                    inhibit_cnt <= '0;
                end
                INHIBIT: begin
                    inhibit_cnt <= inhibit_cnt + 1'b1;
                end
                default: begin
                    if (clk_fall) begin
                        edge_cnt <= edge_cnt + 4'd1;
                    end
                end
            endcase
            if (state == STOP && clk_fall) begin
                ack_bit <= data_sync;
            end
        end
    end

    // Next-state and output decode. The watchdog override comes last so
    // a timeout always releases both lines and returns to IDLE.
    always_comb begin
        next_state       = state;
        o_ready          = 1'b0;
        o_clk_drive_low  = 1'b0;
        o_data_drive_low = 1'b0;
        o_done           = 1'b0;
        o_error          = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    next_state = INHIBIT;
                end
            end
            INHIBIT: begin
                o_clk_drive_low = 1'b1;
                if (inhibit_cnt == INHIBIT_LAST) begin
                    o_data_drive_low = 1'b1;
                    next_state       = START;
                end
            end
            START: begin
                o_data_drive_low = 1'b1;
                if (clk_fall) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                o_data_drive_low = ~tx_byte[bit_idx];
                if (clk_fall && edge_cnt == 4'd8) begin
                    next_state = PARITY;
                end
            end
            PARITY: begin
                o_data_drive_low = ~tx_parity;
                if (clk_fall) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (clk_fall) begin
                    next_state = ACK;
                end
            end
            ACK: begin
                o_done     = ~ack_bit;
                o_error    = ack_bit;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (timeout) begin
            next_state       = IDLE;
            o_clk_drive_low  = 1'b0;
            o_data_drive_low = 1'b0;
            o_done           = 1'b0;
            o_error          = 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- directed bench for ps2_host_tx with a PS/2 device
// model clocking at 12.5 kHz against a 1 MHz system clock.
// Build option PS2_TX_TIMEOUT_EN selects the watchdog scenario; without
// it the silent-device stall is exercised instead.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int CLK_FREQ_HZ    = 1_000_000;
    localparam int INHIBIT_CYCLES = CLK_FREQ_HZ / 10000;
    localparam int TIMEOUT_CYCLES = 3000;
    localparam int HALF_PS2       = CLK_FREQ_HZ / 25000;
    localparam int WAIT_LIMIT     = 20000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_byte;
    logic       i_valid;
    logic       o_ready;
    logic       o_clk_drive_low;
    logic       o_data_drive_low;
    logic       o_done;
    logic       o_error;
    logic       dev_clk_low;
    logic       dev_data_low;
    logic       line_clk;
    logic       line_data;

    int compared   = 0;
    int mismatched = 0;

    int done_cnt       = 0;
    int error_cnt      = 0;
    int both_cnt       = 0;
    int idle_drive_cnt = 0;

    logic [7:0] rx_byte;
    logic       rx_parity;
    logic       rx_stop;
    logic       rx_start;
    logic       stuck;
    logic       ready_ok;
    int         inhibit_len;
    int         data_first;
    int         done_before;
    int         error_before;
    int         n;

    assign line_clk  = ~(o_clk_drive_low | dev_clk_low);
    assign line_data = ~(o_data_drive_low | dev_data_low);

    ps2_host_tx #(
        .CLK_FREQ_HZ    (CLK_FREQ_HZ),
        .INHIBIT_CYCLES (INHIBIT_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_byte           (i_byte),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .io_clk_mouse     (line_clk),
        .io_data_mouse    (line_data),
        .o_clk_drive_low  (o_clk_drive_low),
        .o_data_drive_low (o_data_drive_low),
        .o_done           (o_done),
        .o_error          (o_error)
    );

    always #5 clk = ~clk;

    // Pulse and protocol monitors sampled away from the active edge.
    always @(negedge clk) begin
        if (o_done) done_cnt++;
        if (o_error) error_cnt++;
        if (o_done && o_error) both_cnt++;
        if (o_ready && (o_clk_drive_low || o_data_drive_low)) idle_drive_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One-cycle send request; returns at the first negedge after acceptance.
    task automatic applyStimulus(input logic [7:0] value);
        @(negedge clk);
        i_byte  = value;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    // Device side of a host-to-device frame: waits out the inhibit, checks
    // the start bit, then generates n_edges clock pulses, sampling the
    // data line at the end of each low phase.
    task automatic deviceTransfer(input int n_edges, input logic nack,
                                  output logic [7:0] byte_seen, output logic parity_seen,
                                  output logic stop_seen, output logic start_seen,
                                  output int inh_len, output int data_at, output logic hung);
        int guard;
        byte_seen   = '0;
        parity_seen = 1'b0;
        stop_seen   = 1'b0;
        inh_len     = 0;
        data_at     = 0;
        guard       = 0;
        while (o_clk_drive_low === 1'b1 && guard < WAIT_LIMIT) begin
            inh_len++;
            if (o_data_drive_low && data_at == 0) data_at = inh_len;
            guard++;
            @(negedge clk);
        end
        hung       = (guard >= WAIT_LIMIT);
        start_seen = line_data;
        for (int e = 1; e <= n_edges; e++) begin
            if (e == 11 && !nack) dev_data_low = 1'b1;
            repeat (HALF_PS2) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF_PS2) @(negedge clk);
            if (e <= 8) byte_seen[e-1] = line_data;
            else if (e == 9) parity_seen = line_data;
            else if (e == 10) stop_seen = line_data;
            dev_clk_low = 1'b0;
        end
        dev_data_low = 1'b0;
    endtask

    task automatic waitReady(output logic ok);
        int guard;
        guard = 0;
        while (o_ready !== 1'b1 && guard < WAIT_LIMIT) begin
            guard++;
            @(negedge clk);
        end
        ok = o_ready;
    endtask

    initial begin
        rst          = 1'b1;
        i_byte       = '0;
        i_valid      = 1'b0;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        #1;
        checkOutput("reset_ready", o_ready, 1);
        checkOutput("reset_clk_drive", o_clk_drive_low, 0);
        checkOutput("reset_data_drive", o_data_drive_low, 0);
        checkOutput("reset_done", o_done, 0);
        checkOutput("reset_error", o_error, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] device traffic while idle");
        for (int p = 0; p < 3; p++) begin
            dev_data_low = p[0];
            dev_clk_low  = 1'b1;
            repeat (HALF_PS2) @(negedge clk);
            dev_clk_low  = 1'b0;
            repeat (HALF_PS2) @(negedge clk);
        end
        dev_data_low = 1'b0;
        checkOutput("idle_traffic_ready", o_ready, 1);
        checkOutput("idle_traffic_drive", idle_drive_cnt, 0);

        $display("[TB] send 0xF4 with ACK");
        done_before  = done_cnt;
        error_before = error_cnt;
        applyStimulus(PS2_CMD_ENABLE_REPORTING);
        checkOutput("f4_ready_low", o_ready, 0);
        deviceTransfer(11, 1'b0, rx_byte, rx_parity, rx_stop, rx_start, inhibit_len, data_first, stuck);
        checkOutput("f4_not_hung", stuck, 0);
        checkOutput("f4_inhibit_len", inhibit_len, 100);
        checkOutput("f4_data_low_last_inhibit", data_first, 100);
        checkOutput("f4_start_bit", rx_start, 0);
        checkOutput("f4_bits", rx_byte, 8'hF4);
        checkOutput("f4_parity", rx_parity, 0);
        checkOutput("f4_stop", rx_stop, 1);
        waitReady(ready_ok);
        checkOutput("f4_ready_back", ready_ok, 1);
        checkOutput("f4_done_once", done_cnt - done_before, 1);
        checkOutput("f4_no_error", error_cnt - error_before, 0);

        $display("[TB] send 0x00");
        applyStimulus(8'h00);
        deviceTransfer(11, 1'b0, rx_byte, rx_parity, rx_stop, rx_start, inhibit_len, data_first, stuck);
        checkOutput("z_bits", rx_byte, 8'h00);
        checkOutput("z_parity", rx_parity, 1);
        checkOutput("z_stop", rx_stop, 1);

        $display("[TB] send 0xFF");
        applyStimulus(PS2_CMD_RESET);
        deviceTransfer(11, 1'b0, rx_byte, rx_parity, rx_stop, rx_start, inhibit_len, data_first, stuck);
        checkOutput("ff_bits", rx_byte, 8'hFF);
        checkOutput("ff_parity", rx_parity, 1);

        $display("[TB] send 0x55 with NACK");
        waitReady(ready_ok);
        done_before  = done_cnt;
        error_before = error_cnt;
        applyStimulus(8'h55);
        deviceTransfer(11, 1'b1, rx_byte, rx_parity, rx_stop, rx_start, inhibit_len, data_first, stuck);
        waitReady(ready_ok);
        checkOutput("nack_bits", rx_byte, 8'h55);
        checkOutput("nack_parity", rx_parity, 1);
        checkOutput("nack_error_once", error_cnt - error_before, 1);
        checkOutput("nack_no_done", done_cnt - done_before, 0);

        $display("[TB] reset during bit 4 of 0xA5");
        done_before  = done_cnt;
        error_before = error_cnt;
        applyStimulus(8'hA5);
        deviceTransfer(5, 1'b0, rx_byte, rx_parity, rx_stop, rx_start, inhibit_len, data_first, stuck);
        checkOutput("rst_bit4_driven", o_data_drive_low, 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_clk_rel", o_clk_drive_low, 0);
        checkOutput("rst_mid_data_rel", o_data_drive_low, 0);
        checkOutput("rst_mid_ready", o_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_mid_no_done", done_cnt - done_before, 0);
        checkOutput("rst_mid_no_error", error_cnt - error_before, 0);
        applyStimulus(PS2_CMD_RESET);
        deviceTransfer(11, 1'b0, rx_byte, rx_parity, rx_stop, rx_start, inhibit_len, data_first, stuck);
        waitReady(ready_ok);
        checkOutput("post_rst_bits", rx_byte, 8'hFF);
        checkOutput("post_rst_parity", rx_parity, 1);
        checkOutput("post_rst_done", done_cnt - done_before, 1);

        $display("[TB] held request 0x3C then 0xC3");
        done_before = done_cnt;
        @(negedge clk);
        i_byte  = 8'h3C;
        i_valid = 1'b1;
        @(negedge clk);
        i_byte  = 8'hC3;
        deviceTransfer(11, 1'b0, rx_byte, rx_parity, rx_stop, rx_start, inhibit_len, data_first, stuck);
        checkOutput("held_first_bits", rx_byte, 8'h3C);
        checkOutput("held_first_done", done_cnt - done_before, 1);
        checkOutput("held_second_accepted", o_ready, 0);
        i_valid = 1'b0;
        deviceTransfer(11, 1'b0, rx_byte, rx_parity, rx_stop, rx_start, inhibit_len, data_first, stuck);
        waitReady(ready_ok);
        checkOutput("held_second_bits", rx_byte, 8'hC3);
        checkOutput("held_second_parity", rx_parity, 1);
        checkOutput("held_second_done", done_cnt - done_before, 2);

`ifdef PS2_TX_TIMEOUT_EN
        $display("[TB] silent device, watchdog enabled");
        error_before = error_cnt;
        applyStimulus(PS2_CMD_ENABLE_REPORTING);
        n = 1;
        while (o_error !== 1'b1 && n < TIMEOUT_CYCLES + 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_cycle", n, 3000);
        checkOutput("timeout_error", o_error, 1);
        checkOutput("timeout_no_done", o_done, 0);
        checkOutput("timeout_clk_rel", o_clk_drive_low, 0);
        checkOutput("timeout_data_rel", o_data_drive_low, 0);
        @(negedge clk);
        checkOutput("timeout_idle", o_ready, 1);
        checkOutput("timeout_error_once", error_cnt - error_before, 1);
`else
        $display("[TB] silent device, no watchdog");
        error_before = error_cnt;
        applyStimulus(PS2_CMD_ENABLE_REPORTING);
        repeat (TIMEOUT_CYCLES + 100) @(negedge clk);
        checkOutput("stall_not_ready", o_ready, 0);
        checkOutput("stall_start_held", o_data_drive_low, 1);
        checkOutput("stall_clk_rel", o_clk_drive_low, 0);
        checkOutput("stall_no_error", error_cnt - error_before, 0);
        rst = 1'b1;
        #1;
        checkOutput("stall_rst_ready", o_ready, 1);
        checkOutput("stall_rst_data_rel", o_data_drive_low, 0);
        @(negedge clk);
        rst = 1'b0;
`endif

        repeat (5) @(negedge clk);
        checkOutput("never_done_and_error", both_cnt, 0);
        checkOutput("never_drive_in_idle", idle_drive_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
